// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared widths, state encoding and IEEE constant helpers for the divide post-normalizer.
package fp_div_pkg;
  localparam int MANT_W = 23;
  localparam int EXP_W = 8;
  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, OUT} state_t;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even increment of a mantissa given guard and sticky.
module fp_round_rne #(
  parameter int W = 24
) (
  input  logic [W-1:0] mant,
  input  logic         g,
  input  logic         s,
  output logic [W-1:0] mant_r,
  output logic         carry,
  output logic         inexact
);
  assign {carry, mant_r} = {1'b0, mant} + (W+1)'(g & (s | mant[0]));
  assign inexact = g | s;
endmodule

// File: rtl/fp_div_normalize.sv
// fp_div_normalize: normalizes, denormalizes, rounds and packs the divider quotient,
// then holds the IEEE result on a valid/ready output.
module fp_div_normalize
  import fp_div_pkg::*;
#(
  parameter int MANT_WIDTH = MANT_W,
  parameter int EXP_WIDTH = EXP_W,
  parameter int Q_WIDTH = MANT_WIDTH + 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [Q_WIDTH-1:0]              q_in,
  input  logic [Q_WIDTH-1:0]              r_in,
  input  logic [EXP_WIDTH+1:0]            exp_in,
  input  logic                            sign_in,
  input  logic                            spec_nan,
  input  logic                            spec_inf,
  input  logic                            spec_zero,
  input  logic                            dz_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   result,
  output logic                            flag_ovf,
  output logic                            flag_unf,
  output logic                            flag_inx,
  output logic                            flag_dz
);
  localparam int EW2 = EXP_WIDTH + 2;
  localparam int RW = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int CW = $clog2(MANT_WIDTH + 4);
  localparam logic signed [EW2-1:0] EMAX = EW2'(exp_max(EXP_WIDTH));
  localparam logic [RW-1:0] INF = {1'b0, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  localparam logic [RW-1:0] QNAN = INF | (RW'(1) << (MANT_WIDTH - 1));
  state_t state, nxt;
  logic [Q_WIDTH-1:0] q, q_n;
  logic signed [EW2-1:0] e, e_n, e_r;
  logic signed [EW2:0] sh;
  logic [CW-1:0] cnt, cnt_n;
  logic sgn, rsticky, sticky, ovf_p, tiny, spec, ovf_r;
  logic [MANT_WIDTH:0] mant_r;
  logic carry, inexact;
  logic [EXP_WIDTH-1:0] e_field;
  assign spec = spec_nan | spec_inf | spec_zero;
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  assign q_n = q[Q_WIDTH-1] ? q : q << 1;
  assign e_n = q[Q_WIDTH-1] ? e : e - EW2'(1);
  // widened by one bit so 1-e cannot wrap for the most negative exponent
  assign sh = (EW2+1)'(1) - (EW2+1)'(e_n);
  assign cnt_n = sh > (EW2+1)'(MANT_WIDTH + 3) ? CW'(MANT_WIDTH + 3) : CW'(sh);
  fp_round_rne #(.W(MANT_WIDTH + 1)) u_round (
    .mant    (q[Q_WIDTH-1:3]),
    .g       (q[2]),
    .s       (|q[1:0] | rsticky | sticky),
    .mant_r  (mant_r),
    .carry   (carry),
    .inexact (inexact)
  );
  assign e_r = e + (carry ? EW2'(1) : EW2'(0));
  assign ovf_r = ovf_p | (e_r >= EMAX);
  assign e_field = e == 0 ? {{(EXP_WIDTH-1){1'b0}}, mant_r[MANT_WIDTH]} : e_r[EXP_WIDTH-1:0];
  always_comb begin
    nxt = state;
    nxt = state == IDLE   ? (in_valid ? (spec ? OUT : NORM) : IDLE) :
          state == NORM   ? (e_n > 0 ? ROUND : DENORM) :
          state == DENORM ? (cnt == CW'(1) ? ROUND : DENORM) :
          state == ROUND  ? OUT :
                            (out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
      e <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      rsticky <= 1'b0;
      sticky <= 1'b0;
      ovf_p <= 1'b0;
      tiny <= 1'b0;
      result <= '0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
      flag_dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          q <= q_in;
          e <= exp_in;
          sgn <= sign_in;
          rsticky <= |r_in;
          sticky <= 1'b0;
          ovf_p <= 1'b0;
          tiny <= 1'b0;
          flag_dz <= dz_in;
          if (spec) begin
            result <= spec_nan ? QNAN : {sign_in, spec_inf ? INF[RW-2:0] : (RW-1)'(0)};
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
          end
        end
        NORM: begin
          q <= q_n;
          e <= e_n;
          ovf_p <= e_n >= EMAX;
          tiny <= e_n <= 0;
          cnt <= cnt_n;
        end
        DENORM: begin
          q <= q >> 1;
          sticky <= sticky | q[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) e <= '0;
        end
        ROUND: begin
          result <= ovf_r ? {sgn, INF[RW-2:0]} : {sgn, e_field, mant_r[MANT_WIDTH-1:0]};
          flag_ovf <= ovf_r;
          flag_inx <= ovf_r | inexact;
          flag_unf <= tiny & inexact;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_normalize.sv
// tb_fp_div_normalize: directed and random divide post-normalization checks against an
// arithmetic reference model.
module tb_fp_div_normalize;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [26:0] q_in = '0, r_in = '0;
  logic [9:0] exp_in = '0;
  logic sign_in = 1'b0, spec_nan = 1'b0, spec_inf = 1'b0, spec_zero = 1'b0, dz_in = 1'b0;
  logic [31:0] result;
  logic flag_ovf, flag_unf, flag_inx, flag_dz;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  fp_div_normalize dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q_in(q_in), .r_in(r_in), .exp_in(exp_in), .sign_in(sign_in),
    .spec_nan(spec_nan), .spec_inf(spec_inf), .spec_zero(spec_zero), .dz_in(dz_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx), .flag_dz(flag_dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // value = q * 2^-26 * 2^(e-127); shift into the denormal range in one step, then round
  function automatic void model(input logic [26:0] qi, input logic [26:0] ri, input int ei,
                                input bit s, input bit nan, input bit inf, input bit zero,
                                output logic [31:0] res, output logic [2:0] fl, output int lat);
    longint qq = longint'(qi), m;
    int e = ei, k;
    bit tiny = 0, st = 0, g, inx, ovf;
    if (nan || inf || zero) begin
      res = nan ? 32'h7FC00000 : inf ? {s, 31'h7F800000} : {s, 31'h0};
      fl = 3'b000;
      lat = 1;
      return;
    end
    if (qq < (64'd1 << 26)) begin qq = qq * 2; e = e - 1; end
    lat = 3;
    if (e <= 0) begin
      tiny = 1;
      k = (1 - e > 26) ? 26 : 1 - e;
      st = (qq % (64'd1 << k)) != 0;
      qq = qq / (64'd1 << k);
      e = 0;
      lat = 3 + k;
    end
    st = st || ri != 0 || (qq % 4) != 0;
    g = ((qq / 4) % 2) == 1;
    m = qq / 8;
    inx = g | st;
    if (g && (st || (m % 2) == 1)) m = m + 1;
    if (tiny) e = (m >= (64'd1 << 23)) ? 1 : 0;
    else if (m >= (64'd1 << 24)) begin m = 64'd1 << 23; e = e + 1; end
    ovf = e >= 255;
    res = ovf ? {s, 31'h7F800000} : {s, 8'(e), 23'(m)};
    fl = {ovf, tiny & inx, inx | ovf};
  endfunction

  task automatic do_op(input logic [26:0] q, input logic [26:0] r, input int e, input bit s,
                       input bit nan, input bit inf, input bit zero, input bit dz, input int hold);
    logic [31:0] xr;
    logic [2:0] xf;
    int xl, lat;
    model(q, r, e, s, nan, inf, zero, xr, xf, xl);
    @(negedge clk);
    q_in = q; r_in = r; exp_in = 10'(e); sign_in = s;
    spec_nan = nan; spec_inf = inf; spec_zero = zero; dz_in = dz;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(xl));
    chk("result", 64'(result), 64'(xr));
    chk("flags_ovf_unf_inx_dz", 64'({flag_ovf, flag_unf, flag_inx, flag_dz}), 64'({xf, dz}));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid_result", 64'({out_valid, in_ready, result}), 64'({2'b10, xr}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_handshake", 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    #12;
    chk("reset_state", 64'({out_valid, in_ready, result, flag_ovf, flag_unf, flag_inx, flag_dz}),
        64'({2'b01, 32'h0, 4'h0}));
    @(negedge clk) rst = 1'b1;
    do_op(27'h4000000, 27'h0, 128, 0, 0, 0, 0, 0, 0);
    do_op(27'h2AAAAAA, 27'h123, 126, 0, 0, 0, 0, 0, 0);
    do_op(27'h4000000, 27'h0, 300, 1, 0, 0, 0, 0, 0);
    do_op(27'h4000000, 27'h0, -2, 0, 0, 0, 0, 0, 0);
    do_op(27'h4000000, 27'h5, -2, 0, 0, 0, 0, 0, 0);
    do_op(27'h7FFFFFF, 27'h1, 254, 0, 0, 0, 0, 0, 1);
    do_op(27'h7FFFFFF, 27'h0, 0, 0, 0, 0, 0, 0, 0);
    do_op(27'h4000000, 27'h0, -100, 1, 0, 0, 0, 0, 0);
    do_op(27'h0, 27'h0, 0, 0, 1, 0, 0, 0, 5);
    do_op(27'h0, 27'h0, 0, 1, 0, 1, 0, 1, 2);
    do_op(27'h0, 27'h0, 0, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    q_in = 27'h4000000; r_in = '0; exp_in = 10'(-20); sign_in = 0;
    spec_nan = 0; spec_inf = 0; spec_zero = 0; dz_in = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("abort_reset", 64'({out_valid, in_ready}), 64'b01);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_output", 64'({out_valid, in_ready}), 64'b01);
    do_op(27'h4000000, 27'h0, 128, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      int sel = int'($urandom_range(0, 19));
      do_op(27'($urandom_range(32'h2000001, 32'h7FFFFFF)),
            ($urandom_range(0, 1) == 1) ? 27'($urandom) : 27'h0,
            int'($urandom_range(0, 340)) - 40, 1'($urandom),
            sel == 0, sel == 1, sel == 2, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
